// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin N:1 AXI-Stream arbiter with a single registered
// output stage that tags each forwarded beat with its source index.
// Optional macro AXIS_ARB_PKT_LOCK_EN: when defined the grant is held for a
// whole packet (released on an accepted tlast beat); when undefined every
// accepted beat releases the grant (beat-level arbitration).
module axis_rr_arbiter #(
  parameter  int c_WIDTH = 8,
  parameter  int c_NUM   = 4,
  localparam int c_ID_W  = $clog2(c_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [c_NUM*c_WIDTH-1:0]   s_axis_tdata,
  input  logic [c_NUM-1:0]           s_axis_tvalid,
  input  logic [c_NUM-1:0]           s_axis_tlast,
  output logic [c_NUM-1:0]           s_axis_tready,
  output logic [c_WIDTH-1:0]         m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic [c_ID_W-1:0]          m_axis_tid,
  input  logic                       m_axis_tready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(c_NUM - 1);

  state_t              state_q;
  state_t              state_d;
  logic [c_ID_W-1:0]   ptr_q;
  logic [c_ID_W-1:0]   grant_q;

  logic                slot_free;
  logic                req_any;
  logic [c_ID_W-1:0]   rr_pick;
  logic [c_ID_W-1:0]   scan_idx;
  logic                sel_valid;
  logic                sel_last;
  logic [c_WIDTH-1:0]  sel_data;
  logic                in_beat;
  logic                grant_done;

  // The output register can take a new beat when empty or being drained now.
  assign slot_free = !m_axis_tvalid || m_axis_tready;

  // Round-robin search: first requester at or after ptr, wrapping modulo c_NUM.
  always_comb begin
    req_any  = 1'b0;
    rr_pick  = ptr_q;
    scan_idx = ptr_q;
    for (int k = 0; k < c_NUM; k++) begin
      if (!req_any && s_axis_tvalid[scan_idx]) begin
        req_any = 1'b1;
        rr_pick = scan_idx;
      end
      scan_idx = (scan_idx == c_LAST_ID) ? '0 : scan_idx + 1'b1;
    end
  end

  // Select the granted stream's valid, last and data.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < c_NUM; i++) begin
      if (grant_q == c_ID_W'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*c_WIDTH +: c_WIDTH];
      end
    end
  end

  // Only the granted stream sees ready, and only while BUSY with a free slot.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < c_NUM; i++) begin
      s_axis_tready[i] = (state_q == BUSY) && slot_free && (grant_q == c_ID_W'(i));
    end
  end

  assign in_beat = (state_q == BUSY) && slot_free && sel_valid;

`ifdef AXIS_ARB_PKT_LOCK_EN
  assign grant_done = in_beat && sel_last;
`else
  assign grant_done = in_beat;
`endif

  // Next-state logic: arbitrate in IDLE, hold the grant in BUSY until released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any)    state_d = BUSY;
      BUSY:    if (grant_done) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant is latched only in IDLE; ptr advances past the grant on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (state_q == IDLE && req_any) begin
        grant_q <= rr_pick;
      end
      if (grant_done) begin
        ptr_q <= (grant_q == c_LAST_ID) ? '0 : grant_q + 1'b1;
      end
    end
  end

  // Output register: load on an input beat, otherwise empty on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (in_beat) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tlast  <= sel_last;
      m_axis_tid    <= grant_q;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: self-checking bench for axis_rr_arbiter (c_NUM=4, c_WIDTH=8).
// Expected output order comes from a queue-based round-robin packet model.
module tb_axis_rr_arbiter;

  localparam int c_WIDTH = 8;
  localparam int c_NUM   = 4;

`ifdef AXIS_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] tid;
    int         cyc;
  } out_t;

  typedef struct {
    logic [3:0] valid;
    logic       mr;
    logic [3:0] exp_ready;
    logic       exp_mvalid;
    logic [7:0] exp_data;
    logic [1:0] exp_tid;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_data;
  logic [3:0]  s_valid;
  logic [3:0]  s_last;
  logic [3:0]  s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic [1:0]  m_tid;
  logic        m_ready;

  beat_t src_q [c_NUM][$];
  out_t  out_q [$];
  out_t  exp_q [$];
  vec_t  vecs  [10];

  int         n_pass;
  int         n_checks;
  int         cycle;
  int         model_ptr;
  bit         hold_pending;
  logic [11:0] held;

  axis_rr_arbiter #(.c_WIDTH(c_WIDTH), .c_NUM(c_NUM)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tlast  (m_last),
    .m_axis_tid    (m_tid),
    .m_axis_tready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < c_NUM; i++) if (src_q[i].size() > 0) e = 1'b0;
    return e;
  endfunction

  task automatic push_beat(input int s, input logic [7:0] d, input logic l);
    src_q[s].push_back('{data: d, last: l});
  endtask

  // Round-robin model: whole packets (lock) or single beats per grant.
  function automatic void build_expected();
    beat_t m [c_NUM][$];
    beat_t b;
    int    g;
    int    idx;
    bit    found;
    bit    done;
    for (int i = 0; i < c_NUM; i++) m[i] = src_q[i];
    done = 1'b0;
    while (!done) begin
      found = 1'b0;
      g = 0;
      for (int k = 0; k < c_NUM; k++) begin
        idx = (model_ptr + k) % c_NUM;
        if (!found && m[idx].size() > 0) begin
          found = 1'b1;
          g = idx;
        end
      end
      if (!found) begin
        done = 1'b1;
      end else begin
        do begin
          b = m[g].pop_front();
          exp_q.push_back('{data: b.data, last: b.last, tid: 2'(g), cyc: 0});
        end while (LOCK && !b.last && m[g].size() > 0);
        model_ptr = (g + 1) % c_NUM;
      end
    end
  endfunction

  // One clock cycle: present source heads, run per-cycle checks, log handshakes.
  task automatic apply_stimulus(input logic mr, input bit stall_chk);
    for (int i = 0; i < c_NUM; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i]          = 1'b1;
        s_data[i*8 +: 8]    = src_q[i][0].data;
        s_last[i]           = src_q[i][0].last;
      end else begin
        s_valid[i]          = 1'b0;
        s_data[i*8 +: 8]    = 8'h00;
        s_last[i]           = 1'b0;
      end
    end
    m_ready = mr;
    #1;
    check_output("ready_onehot", 64'($countones(s_ready) <= 1), 64'd1);
    if (hold_pending) check_output("hold_stable", 64'({m_valid, m_data, m_last, m_tid}), 64'(held));
    if (stall_chk) begin
      check_output("stall_ready", 64'(s_ready), 64'd0);
      check_output("stall_data", 64'({m_valid, m_data}), 64'({1'b1, 8'hA5}));
    end
    hold_pending = m_valid && !m_ready;
    held = {m_valid, m_data, m_last, m_tid};
    for (int i = 0; i < c_NUM; i++) begin
      if (s_valid[i] && s_ready[i]) void'(src_q[i].pop_front());
    end
    if (m_valid && m_ready) out_q.push_back('{data: m_data, last: m_last, tid: m_tid, cyc: cycle});
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      apply_stimulus(rand_ready ? 1'($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
      n++;
      done = all_empty() && !m_valid;
    end
    check_output("drain_done", 64'(done), 64'd1);
  endtask

  task automatic compare_logs(input string tag, input bit timing);
    int n;
    int gap;
    check_output({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_output({tag, "_beat"}, 64'({out_q[i].data, out_q[i].last, out_q[i].tid}),
                   64'({exp_q[i].data, exp_q[i].last, exp_q[i].tid}));
      if (timing && i > 0) begin
        gap = (LOCK && !exp_q[i-1].last) ? 1 : 2;
        check_output({tag, "_gap"}, 64'(out_q[i].cyc - out_q[i-1].cyc), 64'(gap));
      end
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    m_ready = 1'b0;
    for (int i = 0; i < c_NUM; i++) src_q[i].delete();
    out_q.delete();
    exp_q.delete();
    hold_pending = 1'b0;
    model_ptr = 0;
    repeat (2) @(negedge clk);
    check_output("reset_state", 64'({s_ready, m_valid, m_data, m_last, m_tid}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Main sequence: reset, vector table, directed corner cases, random traffic.
  initial begin
    int   stall_left;
    int   n;
    bit   done;
    logic mr;
    bit   stall_now;

    n_pass = 0;
    n_checks = 0;
    cycle = 0;
    do_reset();
    check_output("post_reset_state", 64'({s_ready, m_valid, m_data, m_last, m_tid}), 64'd0);

    // Single-beat packets on every stream, so the table holds in both modes.
    vecs[0] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[1] = '{4'b1010, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0};
    vecs[2] = '{4'b1000, 1'b1, 4'b0000, 1'b1, 8'hA1, 2'd1};
    vecs[3] = '{4'b1000, 1'b1, 4'b1000, 1'b0, 8'h00, 2'd0};
    vecs[4] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3};
    vecs[5] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3};
    vecs[6] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3};
    vecs[7] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA3, 2'd3};
    vecs[8] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA0, 2'd0};
    vecs[9] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    for (int r = 0; r < 10; r++) begin
      s_data  = 32'hA3A2A1A0;
      s_last  = 4'b1111;
      s_valid = vecs[r].valid;
      m_ready = vecs[r].mr;
      #1;
      check_output("vec_ready", 64'(s_ready), 64'(vecs[r].exp_ready));
      check_output("vec_mvalid", 64'(m_valid), 64'(vecs[r].exp_mvalid));
      if (vecs[r].exp_mvalid)
        check_output("vec_beat", 64'({m_data, m_last, m_tid}), 64'({vecs[r].exp_data, 1'b1, vecs[r].exp_tid}));
      @(posedge clk);
      cycle++;
      @(negedge clk);
    end
    model_ptr = 1;

    $display("[TB] idle test");
    s_valid = '0;
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(1'b1, 1'b0);
      check_output("idle_ready", 64'(s_ready), 64'd0);
      check_output("idle_mvalid", 64'(m_valid), 64'd0);
    end

    $display("[TB] single packet test");
    push_beat(2, 8'h11, 1'b0);
    push_beat(2, 8'h22, 1'b0);
    push_beat(2, 8'h33, 1'b1);
    build_expected();
    drain(60, 1'b0);
    compare_logs("t1", 1'b1);

    $display("[TB] backpressure test");
    push_beat(3, 8'h30, 1'b1);
    push_beat(0, 8'hA4, 1'b0);
    push_beat(0, 8'hA5, 1'b0);
    push_beat(0, 8'hA6, 1'b1);
    push_beat(1, 8'h77, 1'b1);
    build_expected();
    stall_left = 5;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      stall_now = m_valid && (m_data == 8'hA5) && (stall_left > 0);
      mr = !stall_now;
      if (stall_now) stall_left--;
      apply_stimulus(mr, stall_now);
      n++;
      done = all_empty() && !m_valid;
    end
    check_output("t3_drain_done", 64'(done), 64'd1);
    check_output("t3_stalls_seen", 64'(stall_left), 64'd0);
    compare_logs("t3", 1'b0);

    $display("[TB] contention test");
    do_reset();
    push_beat(0, 8'h01, 1'b0);
    push_beat(0, 8'h02, 1'b1);
    push_beat(1, 8'h11, 1'b0);
    push_beat(1, 8'h12, 1'b1);
    push_beat(3, 8'h31, 1'b0);
    push_beat(3, 8'h32, 1'b1);
    build_expected();
    drain(100, 1'b0);
    compare_logs("t2", 1'b1);

    $display("[TB] interleave test");
    for (int b = 0; b < 3; b++) begin
      push_beat(0, 8'(8'h40 + b), 1'(b == 2));
      push_beat(1, 8'(8'h50 + b), 1'(b == 2));
    end
    build_expected();
    drain(100, 1'b0);
    compare_logs("t5", 1'b1);

    $display("[TB] async reset test");
    for (int b = 0; b < 4; b++) push_beat(3, 8'(8'hD0 + b), 1'(b == 3));
    n = 0;
    while (src_q[3].size() > 2 && n < 20) begin
      apply_stimulus(1'b1, 1'b0);
      n++;
    end
    check_output("t4_mid_packet", 64'({m_valid, m_tid}), 64'({1'b1, 2'd3}));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t4_async_clear", 64'({s_ready, m_valid, m_data, m_last, m_tid}), 64'd0);
    for (int i = 0; i < c_NUM; i++) src_q[i].delete();
    out_q.delete();
    exp_q.delete();
    hold_pending = 1'b0;
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    push_beat(1, 8'h5A, 1'b0);
    push_beat(1, 8'h5B, 1'b1);
    build_expected();
    drain(60, 1'b0);
    compare_logs("t4", 1'b1);

    $display("[TB] random test");
    do_reset();
    for (int round = 0; round < 6; round++) begin
      for (int s = 0; s < c_NUM; s++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_beat(s, 8'($urandom), 1'(b == len - 1));
        end
      end
      build_expected();
      drain(2000, 1'b1);
      compare_logs("rand", 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
